vote_ballot_collector: RTL and testbench
========================================

# vote_ballot_collector

Front-end stage of the four-voter system: samples four raw voter push-buttons, debounces them, and records one sticky ballot per voter during a timed voting window. When the window closes, it presents the 4-bit ballot vector to the downstream 4-input voter (its `I[3:0]` input) with a valid/ready handshake. The ballot is held stable until that stage accepts it.

## Interface
- `DEB_CYCLES`, 4: consecutive equal synchronized samples required before a debounced level changes (≥1).
- `WINDOW_CYCLES`, 1000: length of the voting window in clock cycles (≥2).
- `clk`  in  1  system clock; one clock domain, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  opens a voting window; sampled only in IDLE.
- `clr`  in  1  synchronous abort to IDLE from any state.
- `btn`  in  4  raw, asynchronous voter buttons; bit i is voter i.
- `ballot`  out  4  registered ballot vector; feeds the voter's `I[3:0]`.
- `ballot_valid`  out  1  ballot available; held until accepted.
- `ballot_ready`  in  1  downstream accepts the ballot.
- `voted`  out  4  live sticky per-voter status during the window.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, OPEN, DONE.
- IDLE → OPEN: when `start`=1 and `clr`=0.
  - Window counter loads `WINDOW_CYCLES-1`.
  - `voted` clears to 0.
- OPEN:
  - Counter decrements each cycle.
  - At counter==0, go to DONE. OPEN therefore lasts exactly `WINDOW_CYCLES` cycles.
  - `start` is ignored.
- Vote capture:
  - Each `btn[i]` passes through a 2-flop synchronizer, then a debouncer.
  - A rising edge of the debounced level while in OPEN sets `voted[i]`. The bit is sticky and cannot be retracted; repeat presses have no effect.
  - A button already held (debounced high) before OPEN does not vote until it is released and pressed again.
  - Debouncers run in every state.
- Entering DONE:
  - `ballot` ← `voted`.
  - `ballot_valid` ← 1.
- DONE → IDLE: on the clock edge where `ballot_valid`&&`ballot_ready`. `ballot_valid` falls on that edge, and `ballot` keeps its value until the next DONE entry.
- `clr`:
  - Has priority over all transitions, including same-cycle `start`.
  - On the next edge: state becomes IDLE, `voted`=0, `ballot_valid`=0.
  - `ballot` keeps its value.
- An all-zero ballot (nobody voted) is still delivered.

## Timing
- Reset values:
  - `ballot`=0, `ballot_valid`=0, `voted`=0, `busy`=0.
  - State is IDLE; counters are 0; synchronizers and debounced levels are 0.
- `busy` rises on the edge after `start` is accepted.
- Vote latency: `voted[i]` rises `DEB_CYCLES+3` edges after the first edge that samples `btn[i]` high, provided the button stays stable. This is 2 sync edges, plus `DEB_CYCLES` stability edges, plus 1 capture edge.
- A debounced edge landing on the final OPEN cycle counts. One landing in DONE or later does not.
- `ballot_ready` already high on DONE entry: handshake completes one cycle later; `ballot_valid` is high for exactly 1 cycle.
- Glitches shorter than `DEB_CYCLES` synchronized cycles never change the debounced level.
- Reset mid-operation: immediate return to reset values; no ballot is emitted.

## Configuration
- `VOTE_EARLY_CLOSE_EN` defined:
  - In OPEN, when `voted`==4'b1111, the next edge enters DONE regardless of the counter.
  - Any-order, same-cycle capture of the final vote qualifies.
- Not defined: the window always runs the full `WINDOW_CYCLES`.

## Structure
- Package `vote_pkg`:
  - `NUM_VOTERS`=4.
  - State enum `vote_state_t` {IDLE, OPEN, DONE}.
  - Ballot vector typedef `ballot_t` (logic [NUM_VOTERS-1:0]).
- Sub-module `vote_debounce`:
  - One bit: synchronizer, stability counter, debounced level, rise pulse.
  - Instantiated 4 times.
- Counter widths: `$clog2(WINDOW_CYCLES)` and `$clog2(DEB_CYCLES+1)`.

## Test plan
All scenarios use `DEB_CYCLES`=4 and `WINDOW_CYCLES`=20.
- Reset then idle, `btn`=4'b1111 toggling → all outputs stay 0 and `busy`=0; no vote outside OPEN.
- `start`; press `btn[0]` and `btn[2]` cleanly for 10 cycles → `voted[0]` rises 7 edges after press; DONE after 20 OPEN cycles; `ballot`=4'b0101 with `ballot_valid`=1.
- `ballot_ready` held low for 5 cycles in DONE → `ballot_valid` and `ballot`=4'b0101 stable throughout; one-cycle `ready` → return to IDLE and `busy`=0.
- 2-cycle glitch on `btn[1]`, plus `btn[3]` held high from before `start` → `ballot`=4'b0000, still delivered.
- `clr` mid-window after 2 votes, with `start` asserted the same cycle → IDLE, `voted`=0, no `ballot_valid`.
- With `VOTE_EARLY_CLOSE_EN`, all four pressed together → DONE one edge after `voted`=4'b1111, well before 20 cycles; without the macro, the full 20 cycles elapse.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types for the four-voter ballot front end.
package vote_pkg;

    localparam int NUM_VOTERS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        DONE = 2'd2
    } vote_state_t;

    typedef logic [NUM_VOTERS-1:0] ballot_t;

endpackage

// File: rtl/vote_debounce.sv
// One voter button: 2-flop synchronizer, stability-count debouncer and a
// registered one-cycle pulse on each rising edge of the debounced level.
module vote_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any sample matching the current level restarts the stability run.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                rise  <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vote_ballot_collector.sv
// Collects one sticky vote per voter during a timed window and hands the
// ballot downstream with valid/ready. Optional VOTE_EARLY_CLOSE_EN closes the
// window as soon as all voters have voted.
module vote_ballot_collector
    import vote_pkg::*;
#(
    parameter int DEB_CYCLES    = 4,
    parameter int WINDOW_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clr,
    input  logic [NUM_VOTERS-1:0] btn,
    output ballot_t               ballot,
    output logic                  ballot_valid,
    input  logic                  ballot_ready,
    output ballot_t               voted,
    output logic                  busy
);

    localparam int WCW = $clog2(WINDOW_CYCLES);

    vote_state_t    state;
    logic [WCW-1:0] win_cnt;
    ballot_t        deb_rise;
    ballot_t        capt;
    logic           early;

    for (genvar i = 0; i < NUM_VOTERS; i++) begin : g_deb
        vote_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (btn[i]),
            .rise  (deb_rise[i])
        );
    end

    // Include this cycle's rises so an edge on the last OPEN cycle still counts.
    assign capt = voted | deb_rise;

`ifdef VOTE_EARLY_CLOSE_EN
    assign early = (voted == '1);
`else
    assign early = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            win_cnt      <= '0;
            voted        <= '0;
            ballot       <= '0;
            ballot_valid <= 1'b0;
        end else if (clr) begin
            state        <= IDLE;
            win_cnt      <= '0;
            voted        <= '0;
            ballot_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= OPEN;
                        win_cnt <= WCW'(WINDOW_CYCLES - 1);
                        voted   <= '0;
                    end
                end
                OPEN: begin
                    voted   <= capt;
                    win_cnt <= win_cnt - WCW'(1);
                    if (win_cnt == '0 || early) begin
                        state        <= DONE;
                        win_cnt      <= '0;
                        ballot       <= capt;
                        ballot_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (ballot_valid && ballot_ready) begin
                        state        <= IDLE;
                        ballot_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_ballot_collector.sv
// Directed bench for vote_ballot_collector (DEB_CYCLES=4, WINDOW_CYCLES=20).
module tb_vote_ballot_collector;
    import vote_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n;
    logic    start;
    logic    clr;
    logic    [3:0] btn;
    logic    ready;
    ballot_t ballot;
    logic    ballot_valid;
    ballot_t voted;
    logic    busy;

    int checks = 0;
    int errors = 0;

    vote_ballot_collector #(
        .DEB_CYCLES    (4),
        .WINDOW_CYCLES (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .clr          (clr),
        .btn          (btn),
        .ballot       (ballot),
        .ballot_valid (ballot_valid),
        .ballot_ready (ready),
        .voted        (voted),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        logic       start;
        logic       clr;
        int         hold;
        logic       exp_busy;
        logic [3:0] exp_voted;
        logic       exp_valid;
        logic [3:0] exp_ballot;
    } idle_vec_t;

    idle_vec_t vecs [12];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Window closes n edges from now; valid must be low one edge before.
    task automatic expect_close(input int n, input logic [3:0] exp_ballot);
        tick(n - 1);
        chk("valid_before_close", 32'(ballot_valid), 32'd0);
        tick(1);
        chk("valid_at_close", 32'(ballot_valid), 32'd1);
        chk("ballot_at_close", 32'(ballot), 32'(exp_ballot));
        chk("busy_in_done", 32'(busy), 32'd1);
    endtask

    task automatic accept();
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        chk("valid_after_accept", 32'(ballot_valid), 32'd0);
        chk("busy_after_accept", 32'(busy), 32'd0);
    endtask

    task automatic open_window();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw;
        // Idle phase: buttons toggle, start only together with clr; nothing may move.
        vecs[0]  = '{4'b1111, 1'b0, 1'b0, 8, 1'b0, 4'b0, 1'b0, 4'b0};
        vecs[1]  = '{4'b0000, 1'b0, 1'b0, 8, 1'b0, 4'b0, 1'b0, 4'b0};
        vecs[2]  = '{4'b1111, 1'b0, 1'b0, 8, 1'b0, 4'b0, 1'b0, 4'b0};
        vecs[3]  = '{4'b1010, 1'b0, 1'b0, 2, 1'b0, 4'b0, 1'b0, 4'b0};
        vecs[4]  = '{4'b0101, 1'b0, 1'b0, 3, 1'b0, 4'b0, 1'b0, 4'b0};
        vecs[5]  = '{4'b1111, 1'b0, 1'b0, 8, 1'b0, 4'b0, 1'b0, 4'b0};
        vecs[6]  = '{4'b1111, 1'b1, 1'b1, 1, 1'b0, 4'b0, 1'b0, 4'b0};
        vecs[7]  = '{4'b1111, 1'b0, 1'b1, 1, 1'b0, 4'b0, 1'b0, 4'b0};
        vecs[8]  = '{4'b0000, 1'b0, 1'b0, 8, 1'b0, 4'b0, 1'b0, 4'b0};
        vecs[9]  = '{4'b0110, 1'b0, 1'b0, 8, 1'b0, 4'b0, 1'b0, 4'b0};
        vecs[10] = '{4'b0000, 1'b1, 1'b1, 1, 1'b0, 4'b0, 1'b0, 4'b0};
        vecs[11] = '{4'b0000, 1'b0, 1'b0, 8, 1'b0, 4'b0, 1'b0, 4'b0};

        rst_n = 1'b0; start = 1'b0; clr = 1'b0; btn = 4'b0; ready = 1'b0;
        tick(2);
        chk("rst_ballot", 32'(ballot), 32'd0);
        chk("rst_valid", 32'(ballot_valid), 32'd0);
        chk("rst_voted", 32'(voted), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(1);

        foreach (vecs[k]) begin
            btn = vecs[k].btn; start = vecs[k].start; clr = vecs[k].clr;
            tick(vecs[k].hold);
            start = 1'b0; clr = 1'b0;
            chk($sformatf("idle%0d_busy", k), 32'(busy), 32'(vecs[k].exp_busy));
            chk($sformatf("idle%0d_voted", k), 32'(voted), 32'(vecs[k].exp_voted));
            chk($sformatf("idle%0d_valid", k), 32'(ballot_valid), 32'(vecs[k].exp_valid));
            chk($sformatf("idle%0d_ballot", k), 32'(ballot), 32'(vecs[k].exp_ballot));
        end

        // Clean presses on voters 0 and 2; vote lands 7 edges after press.
        open_window();
        btn = 4'b0101;
        tick(6);
        chk("vote_latency_early", 32'(voted), 32'd0);
        tick(1);
        chk("vote_latency_hit", 32'(voted), 32'b0101);
        tick(3);
        btn = 4'b0000;
        expect_close(10, 4'b0101);

        // Back-pressure: ballot held stable while ready is low.
        for (int c = 0; c < 5; c++) begin
            tick(1);
            chk("hold_valid", 32'(ballot_valid), 32'd1);
            chk("hold_ballot", 32'(ballot), 32'b0101);
        end
        accept();
        chk("ballot_kept_after_accept", 32'(ballot), 32'b0101);

        // Abort mid-window with start in the same cycle.
        open_window();
        btn = 4'b0011;
        tick(7);
        chk("two_votes", 32'(voted), 32'b0011);
        tick(2);
        clr = 1'b1; start = 1'b1;
        tick(1);
        clr = 1'b0; start = 1'b0; btn = 4'b0000;
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_voted", 32'(voted), 32'd0);
        chk("clr_valid", 32'(ballot_valid), 32'd0);
        chk("clr_ballot_kept", 32'(ballot), 32'b0101);
        saw = 0;
        for (int c = 0; c < 25; c++) begin
            tick(1);
            if (ballot_valid || busy) saw = 1;
        end
        chk("no_ballot_after_clr", 32'(saw), 32'd0);

        // Glitch on voter 1, voter 3 held before the window: empty ballot.
        btn = 4'b1000;
        tick(10);
        open_window();
        tick(3);
        btn = 4'b1010;
        tick(2);
        btn = 4'b1000;
        expect_close(15, 4'b0000);
        chk("glitch_voted", 32'(voted), 32'd0);
        accept();
        btn = 4'b0000;
        tick(10);

        // All four voters together; early close only when the macro is built in.
        open_window();
        btn = 4'b1111;
        tick(6);
        chk("all_latency_early", 32'(voted), 32'd0);
        tick(1);
        chk("all_voted", 32'(voted), 32'b1111);
`ifdef VOTE_EARLY_CLOSE_EN
        expect_close(1, 4'b1111);
`else
        expect_close(13, 4'b1111);
`endif
        accept();
        btn = 4'b0000;
        tick(10);

        // Asynchronous reset in the middle of a window.
        open_window();
        btn = 4'b0001;
        tick(8);
        chk("pre_reset_voted", 32'(voted), 32'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_voted", 32'(voted), 32'd0);
        chk("async_rst_ballot", 32'(ballot), 32'd0);
        chk("async_rst_valid", 32'(ballot_valid), 32'd0);
        btn = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        for (int c = 0; c < 25; c++) begin
            tick(1);
            if (ballot_valid || busy) saw = 1;
        end
        chk("no_ballot_after_reset", 32'(saw), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
